// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I constants and fetch FSM state type.
package rv32i_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef enum logic [1:0] {IDLE, RUN, STALL} fetch_state_e;
endpackage

// File: rtl/fetch_ctrl_rv32i_if.sv
// fetch_ctrl_rv32i_if: ROM port, output handshake and redirect bundle of the fetch controller.
interface fetch_ctrl_rv32i_if;
    import rv32i_pkg::*;
    logic [XLEN-1:0] rom_addr;
    logic [XLEN-1:0] rom_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    modport master (
        output rom_addr, out_valid, out_instr, out_pc,
        input  rom_instr, out_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  rom_addr, out_valid, out_instr, out_pc,
        output rom_instr, out_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_ctrl_rv32i.sv
// fetch_ctrl_rv32i: RV32I fetch controller for a 1-cycle synchronous ROM,
// with zero-bubble streaming, stall hold and redirect.
module fetch_ctrl_rv32i
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    fetch_ctrl_rv32i_if.master  bus,
    output logic                busy,
    output logic                misalign_err,
    output logic [XLEN-1:0]     fetch_cnt
);
    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_f_q, pc_f_d, pc_d_q, pc_d_d, fetch_cnt_q, fetch_cnt_d;
    logic            v_d_q, v_d_d, misalign_err_q, misalign_err_d;
    logic [XLEN-1:0] target;
    logic            hold, xfer;

    assign target = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign hold = (state_q != IDLE) & v_d_q & ~bus.out_ready;
    assign bus.out_valid = v_d_q & ~bus.redirect_valid & (state_q != IDLE);
    assign xfer = bus.out_valid & bus.out_ready;
    // While holding, re-read pc_d so the ROM keeps presenting the stalled word.
    assign bus.rom_addr = bus.redirect_valid ? target : hold ? pc_d_q : pc_f_q;
    assign bus.out_pc = pc_d_q;
    assign bus.out_instr = bus.out_valid ? bus.rom_instr : NOP_INSTR;
    assign busy = state_q != IDLE;
    assign misalign_err = misalign_err_q;
    assign fetch_cnt = fetch_cnt_q;

    always_comb begin
        state_d = state_q;
        pc_f_d = pc_f_q;
        pc_d_d = pc_d_q;
        v_d_d = v_d_q;
        misalign_err_d = misalign_err_q | (bus.redirect_valid & (|bus.redirect_pc[1:0]));
        fetch_cnt_d = fetch_cnt_q + {{(XLEN-1){1'b0}}, xfer};
        if (bus.redirect_valid) begin
            if (state_q == IDLE) begin
                pc_f_d = target;
            end else begin
                state_d = RUN;
                pc_d_d = target;
                pc_f_d = target + 32'd4;
                v_d_d = 1'b1;
            end
        end else if (state_q == IDLE) begin
            if (run) begin
                state_d = RUN;
                pc_d_d = pc_f_q;
                pc_f_d = pc_f_q + 32'd4;
                v_d_d = 1'b1;
            end
        end else if (hold) begin
            state_d = STALL;
        end else if (run) begin
            state_d = RUN;
            pc_d_d = pc_f_q;
            pc_f_d = pc_f_q + 32'd4;
            v_d_d = 1'b1;
        end else begin
            state_d = IDLE;
            v_d_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_f_q <= RESET_PC;
            pc_d_q <= RESET_PC;
            v_d_q <= 1'b0;
            misalign_err_q <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            pc_f_q <= pc_f_d;
            pc_d_q <= pc_d_d;
            v_d_q <= v_d_d;
            misalign_err_q <= misalign_err_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl_rv32i.sv
// tb_fetch_ctrl_rv32i: directed and random checks of the fetch controller
// against an instruction-stream reference model and a synchronous ROM.
module tb_fetch_ctrl_rv32i;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        busy, misalign_err;
    logic [31:0] fetch_cnt;
    int          checks = 0, errors = 0;
    logic [31:0] exp_pc, exp_cnt;
    logic        exp_mis, hold_pend, cont_pend;
    logic [31:0] mem [64];

    fetch_ctrl_rv32i_if bus();

    fetch_ctrl_rv32i dut (
        .clock(clock), .reset(reset), .run(run), .bus(bus),
        .busy(busy), .misalign_err(misalign_err), .fetch_cnt(fetch_cnt)
    );

    always #5 clock = ~clock;
    always @(posedge clock) bus.rom_instr <= mem[bus.rom_addr[7:2]];

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return mem[pc[7:2]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
        run = r;
        bus.out_ready = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        #1;
    endtask

    task automatic model_reset();
        exp_pc = 32'h0;
        exp_cnt = 32'h0;
        exp_mis = 1'b0;
        hold_pend = 1'b0;
        cont_pend = 1'b0;
    endtask

    // Reference: transfers form a stream of consecutive words broken only by redirects.
    task automatic tick();
        chk("fetch_cnt", fetch_cnt, exp_cnt);
        chk("misalign_err", 32'(misalign_err), 32'(exp_mis));
        if (bus.redirect_valid) chk("kill", 32'(bus.out_valid), 32'd0);
        if (hold_pend && !bus.redirect_valid) chk("stall_hold", 32'(bus.out_valid), 32'd1);
        if (cont_pend && !bus.redirect_valid) chk("no_bubble", 32'(bus.out_valid), 32'd1);
        if (bus.out_valid) begin
            chk("out_pc", bus.out_pc, exp_pc);
            chk("out_instr", bus.out_instr, rom_word(exp_pc));
        end
        cont_pend = bus.out_valid & bus.out_ready & run;
        hold_pend = bus.out_valid & ~bus.out_ready & ~bus.redirect_valid;
        if (bus.redirect_valid) begin
            exp_pc = {bus.redirect_pc[31:2], 2'b00};
            exp_mis = exp_mis | (|bus.redirect_pc[1:0]);
        end else if (bus.out_valid && bus.out_ready) begin
            exp_pc = exp_pc + 32'd4;
            exp_cnt = exp_cnt + 32'd1;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h00100293; mem[1] = 32'h00000333; mem[2] = 32'h00B00393;
        mem[3] = 32'h00530333; mem[4] = 32'h00128293; mem[5] = 32'hFE72CCE3;
        mem[6] = 32'h00000513;
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        chk("rst_rom_addr", bus.rom_addr, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        // Streaming start: no bubbles after the first fetch.
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("start_idle", 32'(bus.out_valid), 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("s0_pc", bus.out_pc, 32'h0);
        chk("s0_instr", bus.out_instr, 32'h00100293);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("s1_pc", bus.out_pc, 32'h4);
        chk("s1_instr", bus.out_instr, 32'h00000333);
        tick();
        // Three-cycle stall at 0x8.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            chk("stall_pc", bus.out_pc, 32'h8);
            chk("stall_instr", bus.out_instr, 32'h00B00393);
            chk("stall_rom_addr", bus.rom_addr, 32'h8);
            chk("stall_cnt", fetch_cnt, 32'd2);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("unstall_pc", bus.out_pc, 32'h8);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("after_stall_pc", bus.out_pc, 32'hC);
        chk("after_stall_instr", bus.out_instr, 32'h00530333);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        // Redirect to 0xC while 0x14 is presented.
        drive(1'b1, 1'b1, 1'b1, 32'hC);
        chk("redir_valid", 32'(bus.out_valid), 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_pc", bus.out_pc, 32'hC);
        chk("redir_instr", bus.out_instr, 32'h00530333);
        chk("redir_cnt", fetch_cnt, 32'd5);
        tick();
        // Redirect during stall drops the held word.
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h0);
        chk("stall_redir_valid", 32'(bus.out_valid), 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stall_redir_pc", bus.out_pc, 32'h0);
        chk("stall_redir_cnt", fetch_cnt, 32'd6);
        tick();
        // Misaligned redirect.
        drive(1'b1, 1'b1, 1'b1, 32'hE);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("mis_pc", bus.out_pc, 32'hC);
        chk("mis_flag", 32'(misalign_err), 32'd1);
        tick();
        // PC wrap at the top of the address space.
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_top", bus.out_pc, 32'hFFFF_FFFC);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_zero", bus.out_pc, 32'h0);
        chk("mis_sticky", 32'(misalign_err), 32'd1);
        tick();
        // Asynchronous reset in the middle of a cycle.
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_cnt", fetch_cnt, 32'd0);
        chk("arst_misalign", 32'(misalign_err), 32'd0);
        chk("arst_rom_addr", bus.rom_addr, 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("restart_pc", bus.out_pc, 32'h0);
        chk("restart_instr", bus.out_instr, 32'h00100293);
        tick();
        // Random traffic against the stream model.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
                  {($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'h0, 8'($urandom_range(0, 255))});
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b1;
                @(posedge clock);
                @(negedge clock);
                reset = 1'b0;
                model_reset();
            end else begin
                tick();
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
